adc_result_sequencer: RTL and testbench

//  Digital stage directly downstream of the SAR ADC top: triggers conversions and collects their results.
//  - Issues start_conversion pulses, single-shot or at a programmable period.
//  - Synchronises the asynchronous conversion-finished flag and captures the 16-bit result.
//  - Buffers results in a FIFO that the host (Caravel wishbone/logic analyser glue) drains.

---
 rtl/adc_result_sequencer.sv | 126 ++++++++++++
 tb/tb_adc_result_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_result_sequencer.sv
// adc_result_sequencer: triggers SAR ADC conversions, synchronises the finish flag and buffers results in a FIFO
// Ports: clk/rst_n (sync, active-low); enable_in, continuous_in, single_shot_in, period_in, clear_in control;
//   start_conversion_out / conversion_finished_in / result_in talk to the ADC;
//   rd_en_in, rd_data_out, rd_valid_out, level_out drain the FIFO;
//   overflow_out, timeout_out sticky flags; busy_out = FSM not idle.
// Optional: define ADC_SEQ_WINDOW_EN to add win_lo_in, win_hi_in and the sticky win_hit_out out-of-window flag.
module adc_result_sequencer #(
  parameter int DEPTH        = 8,
  parameter int START_CYCLES = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_in,
  input  logic                       continuous_in,
  input  logic                       single_shot_in,
  input  logic [15:0]                period_in,
  input  logic                       clear_in,
  output logic                       start_conversion_out,
  input  logic                       conversion_finished_in,
  input  logic [15:0]                result_in,
  input  logic                       rd_en_in,
  output logic [15:0]                rd_data_out,
  output logic                       rd_valid_out,
  output logic [$clog2(DEPTH):0]     level_out,
  output logic                       overflow_out,
  output logic                       timeout_out,
`ifdef ADC_SEQ_WINDOW_EN
  input  logic [15:0]                win_lo_in,
  input  logic [15:0]                win_hi_in,
  output logic                       win_hit_out,
`endif
  output logic                       busy_out
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [15:0]     per_cnt, per_eff;
  logic            fin_q1, fin_q2, fin_q3, fin_rise;
  logic            start_done, wait_done, hold_done, timeout_set;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, empty, push_req, do_push, do_pop;

  // fin_q1/fin_q2 form the synchroniser; fin_q3 holds the previous synced value for edge detection
  always_ff @(posedge clk)
    if (!rst_n) {fin_q3, fin_q2, fin_q1} <= '0;
    else {fin_q3, fin_q2, fin_q1} <= {fin_q2, fin_q1, conversion_finished_in};

  assign fin_rise    = fin_q2 & ~fin_q3;
  assign per_eff     = (period_in == 16'd0) ? 16'd1 : period_in;
  assign start_done  = cnt == CW'(START_CYCLES - 1);
  assign wait_done   = cnt == CW'(TIMEOUT - 1);
  // per_cnt restarts on START entry, so the next start lands period cycles after this one
  assign hold_done   = per_cnt >= per_eff - 16'd1;
  assign timeout_set = (state == WAIT) & ~fin_rise & wait_done;

  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      per_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state) ? '0 : cnt + CW'(1);
      per_cnt <= (state_nxt == START && state != START) ? 16'd0 :
                 (per_cnt == 16'hFFFF) ? per_cnt : per_cnt + 16'd1;
    end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (enable_in & (continuous_in | single_shot_in)) ? START : IDLE;
      START:   state_nxt = start_done ? WAIT : START;
      WAIT:    state_nxt = fin_rise ? CAPTURE : wait_done ? HOLD : WAIT;
      CAPTURE: state_nxt = HOLD;
      HOLD:    state_nxt = !(continuous_in & enable_in) ? IDLE : hold_done ? START : HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  assign start_conversion_out = state == START;
  assign busy_out             = state != IDLE;

  assign full     = level_out == LW'(DEPTH);
  assign empty    = level_out == '0;
  assign push_req = (state == CAPTURE) & ~clear_in;
  assign do_pop   = rd_en_in & ~empty & ~clear_in;
  // a full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign do_push  = push_req & (~full | do_pop);

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= result_in;

  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_out    <= '0;
      rd_data_out  <= '0;
      rd_valid_out <= 1'b0;
      overflow_out <= 1'b0;
      timeout_out  <= 1'b0;
    end else begin
      wr_ptr       <= clear_in ? '0 : wr_ptr + AW'(do_push);
      rd_ptr       <= clear_in ? '0 : rd_ptr + AW'(do_pop);
      level_out    <= clear_in ? '0 : level_out + LW'(do_push) - LW'(do_pop);
      rd_data_out  <= do_pop ? mem[rd_ptr] : rd_data_out;
      rd_valid_out <= do_pop;
      overflow_out <= clear_in ? 1'b0 : overflow_out | (push_req & full & ~do_pop);
      timeout_out  <= clear_in ? 1'b0 : timeout_out | timeout_set;
    end

`ifdef ADC_SEQ_WINDOW_EN
  always_ff @(posedge clk)
    if (!rst_n) win_hit_out <= 1'b0;
    else win_hit_out <= clear_in ? 1'b0 :
                        win_hit_out | ((state == CAPTURE) & ((result_in < win_lo_in) | (result_in > win_hi_in)));
`endif
endmodule

// File: tb/tb_adc_result_sequencer.sv
// tb_adc_result_sequencer: directed table-driven bench for adc_result_sequencer with a behavioural ADC model
module tb_adc_result_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, enable_in, continuous_in, single_shot_in, clear_in, rd_en_in;
  logic [15:0] period_in;
  logic        start_conversion_out, conversion_finished_in, rd_valid_out;
  logic        overflow_out, timeout_out, busy_out;
  logic [15:0] result_in, rd_data_out;
  logic [3:0]  level_out;
`ifdef ADC_SEQ_WINDOW_EN
  logic [15:0] win_lo, win_hi;
  logic        win_hit_out;
`endif

  logic        fin_auto, fin_man, adc_auto, adc_inc;
  int          adc_delay, conv_n, cyc = 0;
  logic [15:0] res_base;
  int          vectors = 0, miscompares = 0;

  typedef struct {
    logic [15:0] res;
    int          delay;
    logic [15:0] period;
    int          exp_start;
    int          exp_level;
    logic [15:0] exp_data;
  } vec_t;
  vec_t        tbl [4];
  logic [15:0] drain [8];

  assign conversion_finished_in = fin_auto | fin_man;
  assign result_in = res_base + conv_n[15:0];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_result_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .continuous_in(continuous_in),
    .single_shot_in(single_shot_in), .period_in(period_in), .clear_in(clear_in),
    .start_conversion_out(start_conversion_out), .conversion_finished_in(conversion_finished_in),
    .result_in(result_in), .rd_en_in(rd_en_in), .rd_data_out(rd_data_out),
    .rd_valid_out(rd_valid_out), .level_out(level_out), .overflow_out(overflow_out),
    .timeout_out(timeout_out),
`ifdef ADC_SEQ_WINDOW_EN
    .win_lo_in(win_lo), .win_hi_in(win_hi), .win_hit_out(win_hit_out),
`endif
    .busy_out(busy_out)
  );

  // ADC model: after the start pulse ends, wait adc_delay cycles, then hold finish high for 5 cycles
  initial begin
    fin_auto = 1'b0;
    conv_n = 0;
    forever begin
      @(negedge clk);
      if (!adc_inc) conv_n = 0;
      if (adc_auto && start_conversion_out) begin
        while (start_conversion_out) @(negedge clk);
        repeat (adc_delay) @(negedge clk);
        fin_auto = 1'b1;
        repeat (5) @(negedge clk);
        fin_auto = 1'b0;
        if (adc_inc) conv_n++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fire();
    @(negedge clk) single_shot_in = 1'b1;
    @(negedge clk) single_shot_in = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk) clear_in = 1'b1;
    @(negedge clk) clear_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("idle", busy_out, 0);
  endtask

  task automatic wait_start_low();
    int n = 0;
    while (start_conversion_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_low", start_conversion_out, 0);
  endtask

  task automatic pop_chk(string nm, logic [15:0] exp);
    @(negedge clk) rd_en_in = 1'b1;
    @(negedge clk) rd_en_in = 1'b0;
    chk({nm, "_valid"}, rd_valid_out, 1);
    chk({nm, "_data"}, rd_data_out, exp);
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_start"}, start_conversion_out, 0);
    chk({nm, "_data"}, rd_data_out, 0);
    chk({nm, "_valid"}, rd_valid_out, 0);
    chk({nm, "_level"}, level_out, 0);
    chk({nm, "_ovf"}, overflow_out, 0);
    chk({nm, "_tmo"}, timeout_out, 0);
    chk({nm, "_busy"}, busy_out, 0);
  endtask

  initial begin
    int n, t_prev;
    tbl[0] = '{16'hA5A5, 50, 16'd10, 4, 1, 16'hA5A5};
    tbl[1] = '{16'h0000, 0, 16'd1, 4, 1, 16'h0000};
    tbl[2] = '{16'hFFFF, 7, 16'd0, 4, 1, 16'hFFFF};
    tbl[3] = '{16'h1234, 200, 16'd3, 4, 1, 16'h1234};
    drain = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h0200};
    rst_n = 1'b0; enable_in = 1'b0; continuous_in = 1'b0; single_shot_in = 1'b0;
    clear_in = 1'b0; rd_en_in = 1'b0; period_in = 16'd10; fin_man = 1'b0;
    adc_auto = 1'b1; adc_inc = 1'b0; adc_delay = 50; res_base = 16'h0;
`ifdef ADC_SEQ_WINDOW_EN
    win_lo = 16'h1000; win_hi = 16'h2000;
`endif
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    enable_in = 1'b1;

    for (int i = 0; i < 4; i++) begin
      res_base = tbl[i].res; adc_delay = tbl[i].delay; period_in = tbl[i].period;
      fire();
      n = 0;
      while (start_conversion_out && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("ss_start_cycles", n, tbl[i].exp_start);
      wait_idle();
      chk("ss_level", level_out, tbl[i].exp_level);
      pop_chk("ss_pop", tbl[i].exp_data);
      @(negedge clk);
      chk("ss_valid_drop", rd_valid_out, 0);
      chk("ss_data_hold", rd_data_out, tbl[i].exp_data);
      chk("ss_level_empty", level_out, 0);
    end

    period_in = 16'd100; adc_delay = 20; res_base = 16'h0100; adc_inc = 1'b1;
    @(negedge clk) continuous_in = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (!start_conversion_out && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("cont_start_seen", start_conversion_out, 1);
      if (i > 0) chk("cont_period", cyc - t_prev, 100);
      t_prev = cyc;
      if (i == 8) begin
        chk("cont_level_before_9th", level_out, 8);
        chk("cont_ovf_before_9th", overflow_out, 0);
        continuous_in = 1'b0;
      end
      wait_start_low();
    end
    n = 0;
    while (!overflow_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cont_overflow", overflow_out, 1);
    chk("cont_level_full", level_out, 8);
    wait_idle();
    adc_inc = 1'b0;

    res_base = 16'h0200; adc_delay = 10;
    fire();
    n = 0;
    while (!fin_auto && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("pp_fin_seen", fin_auto, 1);
    repeat (3) @(negedge clk);
    rd_en_in = 1'b1;
    @(negedge clk) rd_en_in = 1'b0;
    chk("pp_valid", rd_valid_out, 1);
    chk("pp_oldest", rd_data_out, 16'h0100);
    chk("pp_level", level_out, 8);
    wait_idle();
    for (int i = 0; i < 8; i++) pop_chk("drain", drain[i]);
    chk("drain_level", level_out, 0);
    @(negedge clk) rd_en_in = 1'b1;
    @(negedge clk) rd_en_in = 1'b0;
    chk("empty_pop_valid", rd_valid_out, 0);
    chk("empty_pop_data", rd_data_out, 16'h0200);
    chk("ovf_sticky", overflow_out, 1);
    clear();
    chk("ovf_cleared", overflow_out, 0);

    adc_auto = 1'b0;
    fire();
    wait_start_low();
    n = 0;
    while (!timeout_out && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, 4096);
    chk("tmo_flag", timeout_out, 1);
    wait_idle();
    chk("tmo_no_push", level_out, 0);
    clear();
    chk("tmo_cleared", timeout_out, 0);

`ifdef ADC_SEQ_WINDOW_EN
    adc_auto = 1'b1; adc_delay = 5; res_base = 16'h0800;
    fire();
    wait_idle();
    chk("win_low_hit", win_hit_out, 1);
    clear();
    chk("win_cleared", win_hit_out, 0);
    res_base = 16'h1800;
    fire();
    wait_idle();
    chk("win_inside", win_hit_out, 0);
    clear();
`endif

    adc_auto = 1'b1; adc_delay = 5; res_base = 16'h0055;
    fire();
    wait_idle();
    chk("rst_pre_level", level_out, 1);
    pop_chk("rst_pre_pop", 16'h0055);
    res_base = 16'h0066;
    fire();
    wait_idle();
    adc_auto = 1'b0;
    fire();
    wait_start_low();
    repeat (10) @(negedge clk);
    chk("rst_in_wait", busy_out, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    fin_man = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_late_level", level_out, 0);
    chk("rst_late_busy", busy_out, 0);
    chk("rst_late_valid", rd_valid_out, 0);
    fin_man = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
